// File: rtl/data_mem_responder_if.sv
// Processor and host buses of the wide data memory.
// Handshake: a host request is taken on any edge where hostWrEn or hostRdEn is high and hostBusy is low; hostRdValid answers a read with a single-cycle pulse.
interface data_mem_responder_if #(
    parameter int REG_WIDTH           = 12,
    parameter int CORE_COUNT          = 4,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int LANE_SEL_WIDTH      = 2,
    parameter int CYC_WIDTH           = 16
);
    logic                                start;
    logic                                done;
    logic [DATA_MEM_ADDR_WIDTH-1:0]      dataMemAddr;
    logic                                DataMemWrEn;
    logic [REG_WIDTH*CORE_COUNT-1:0]     ProcessorDataOut;
    logic [REG_WIDTH*CORE_COUNT-1:0]     ProcessorDataIn;
    logic                                hostWrEn;
    logic                                hostRdEn;
    logic [DATA_MEM_ADDR_WIDTH-1:0]      hostAddr;
    logic [LANE_SEL_WIDTH-1:0]           hostLane;
    logic [REG_WIDTH-1:0]                hostDataIn;
    logic [REG_WIDTH-1:0]                hostDataOut;
    logic                                hostRdValid;
    logic                                hostBusy;
    logic [CYC_WIDTH-1:0]                runCycles;
    logic                                dbgState;

    modport master (
        output start, done, dataMemAddr, DataMemWrEn, ProcessorDataOut,
        output hostWrEn, hostRdEn, hostAddr, hostLane, hostDataIn,
        input  ProcessorDataIn, hostDataOut, hostRdValid, hostBusy, runCycles, dbgState
    );

    modport slave (
        input  start, done, dataMemAddr, DataMemWrEn, ProcessorDataOut,
        input  hostWrEn, hostRdEn, hostAddr, hostLane, hostDataIn,
        output ProcessorDataIn, hostDataOut, hostRdValid, hostBusy, runCycles, dbgState
    );
endinterface

// File: rtl/data_mem_responder.sv
// Wide data memory shared by a lock-step processor (whole rows) and a host port (single lanes).
// Ownership follows start/done: HOST serves the host port, RUN serves processor writes.
module data_mem_responder #(
    parameter int REG_WIDTH           = 12,
    parameter int CORE_COUNT          = 4,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int LANE_SEL_WIDTH      = 2,
    parameter int CYC_WIDTH           = 16
) (
    input logic                 clk,
    input logic                 rstN,
    data_mem_responder_if.slave bus
);
    localparam int ROW_W = REG_WIDTH * CORE_COUNT;
    localparam int DEPTH = 2 ** DATA_MEM_ADDR_WIDTH;

    localparam logic [0:0] ST_HOST = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [ROW_W-1:0]     mem [DEPTH];

    logic [0:0]           state_q, state_d;
    logic [ROW_W-1:0]     proc_rd_q;
    logic [REG_WIDTH-1:0] host_rd_data_q;
    logic                 host_rd_valid_q;
    logic [CYC_WIDTH-1:0] run_cycles_q, run_cycles_d;

    logic                 lane_ok;
    logic                 host_wr;
    logic                 host_rd;
    logic                 proc_wr;
    logic                 run_enter;
    logic [ROW_W-1:0]     host_row;
    logic [REG_WIDTH-1:0] host_lane_word;

    // Lane-select values past the last core are only possible when the select is wider than needed.
    generate
        if (CORE_COUNT >= (2 ** LANE_SEL_WIDTH)) begin : g_lane_full
            assign lane_ok = 1'b1;
        end else begin : g_lane_chk
            assign lane_ok = (int'(bus.hostLane) < CORE_COUNT);
        end
    endgenerate

    assign host_wr   = (state_q == ST_HOST) && lane_ok && bus.hostWrEn;
    assign host_rd   = (state_q == ST_HOST) && lane_ok && bus.hostRdEn && !bus.hostWrEn;
    assign proc_wr   = (state_q == ST_RUN) && bus.DataMemWrEn;
    assign run_enter = (state_q == ST_HOST) && bus.start;

    always_comb begin
        state_d = state_q;
        if (state_q == ST_HOST) begin
            if (bus.start) state_d = ST_RUN;
        end else begin
            if (bus.done) state_d = ST_HOST;
        end
    end

    // The cycle that samples done closes the run and is not counted.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if (run_enter) begin
            run_cycles_d = CYC_WIDTH'(1);
        end else if ((state_q == ST_RUN) && !bus.done && (run_cycles_q != '1)) begin
            run_cycles_d = run_cycles_q + CYC_WIDTH'(1);
        end
    end

    assign host_row = mem[bus.hostAddr];

    always_comb begin
        host_lane_word = '0;
        for (int l = 0; l < CORE_COUNT; l++) begin
            if (bus.hostLane == LANE_SEL_WIDTH'(l)) host_lane_word = host_row[l*REG_WIDTH +: REG_WIDTH];
        end
    end

    // Array is never reset so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (proc_wr) mem[bus.dataMemAddr] <= bus.ProcessorDataOut;
        for (int l = 0; l < CORE_COUNT; l++) begin
            if (host_wr && (bus.hostLane == LANE_SEL_WIDTH'(l))) begin
                mem[bus.hostAddr][l*REG_WIDTH +: REG_WIDTH] <= bus.hostDataIn;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q         <= ST_HOST;
            proc_rd_q       <= '0;
            host_rd_data_q  <= '0;
            host_rd_valid_q <= 1'b0;
            run_cycles_q    <= '0;
        end else begin
            state_q         <= state_d;
            proc_rd_q       <= mem[bus.dataMemAddr];
            host_rd_valid_q <= host_rd;
            run_cycles_q    <= run_cycles_d;
            if (host_rd) host_rd_data_q <= host_lane_word;
        end
    end

    assign bus.ProcessorDataIn = proc_rd_q;
    assign bus.hostDataOut     = host_rd_data_q;
    assign bus.hostRdValid     = host_rd_valid_q;
    assign bus.hostBusy        = (state_q == ST_RUN);
    assign bus.runCycles       = run_cycles_q;
    assign bus.dbgState        = state_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a full-size instance plus a 3-lane, 4-bit-counter instance.
module tb_data_mem_responder;
    logic clk;
    logic rst_n;

    data_mem_responder_if #(.REG_WIDTH(12), .CORE_COUNT(4), .DATA_MEM_ADDR_WIDTH(12),
                            .LANE_SEL_WIDTH(2), .CYC_WIDTH(16)) bus_a ();
    data_mem_responder_if #(.REG_WIDTH(12), .CORE_COUNT(3), .DATA_MEM_ADDR_WIDTH(4),
                            .LANE_SEL_WIDTH(2), .CYC_WIDTH(4)) bus_b ();

    data_mem_responder #(.REG_WIDTH(12), .CORE_COUNT(4), .DATA_MEM_ADDR_WIDTH(12),
                         .LANE_SEL_WIDTH(2), .CYC_WIDTH(16)) dut_a (
        .clk(clk), .rstN(rst_n), .bus(bus_a.slave)
    );
    data_mem_responder #(.REG_WIDTH(12), .CORE_COUNT(3), .DATA_MEM_ADDR_WIDTH(4),
                         .LANE_SEL_WIDTH(2), .CYC_WIDTH(4)) dut_b (
        .clk(clk), .rstN(rst_n), .bus(bus_b.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [11:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks (instance A) ----------------
    task automatic host_write(input logic [11:0] addr, input logic [1:0] lane, input logic [11:0] data);
        bus_a.hostAddr   = addr;
        bus_a.hostLane   = lane;
        bus_a.hostDataIn = data;
        bus_a.hostWrEn   = 1'b1;
        tick();
        bus_a.hostWrEn   = 1'b0;
    endtask

    task automatic host_read(input logic [11:0] addr, input logic [1:0] lane,
                             input logic [11:0] exp, input bit served);
        bus_a.hostAddr = addr;
        bus_a.hostLane = lane;
        bus_a.hostRdEn = 1'b1;
        if (served) exp_q.push_back(exp);
        tick();
        bus_a.hostRdEn = 1'b0;
    endtask

    // ---------------- scoreboard monitor (instance A host reads) ----------------
    always @(negedge clk) begin
        if (rst_n && bus_a.hostRdValid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_host_rd_valid", 64'(bus_a.hostRdValid), 64'd0);
            end else begin
                chk("host_rd_data", 64'(bus_a.hostDataOut), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        bus_a.start = 0; bus_a.done = 0; bus_a.dataMemAddr = '0; bus_a.DataMemWrEn = 0;
        bus_a.ProcessorDataOut = '0; bus_a.hostWrEn = 0; bus_a.hostRdEn = 0;
        bus_a.hostAddr = '0; bus_a.hostLane = '0; bus_a.hostDataIn = '0;
        bus_b.start = 0; bus_b.done = 0; bus_b.dataMemAddr = '0; bus_b.DataMemWrEn = 0;
        bus_b.ProcessorDataOut = '0; bus_b.hostWrEn = 0; bus_b.hostRdEn = 0;
        bus_b.hostAddr = '0; bus_b.hostLane = '0; bus_b.hostDataIn = '0;

        repeat (3) tick();
        chk("rst_proc_data", 64'(bus_a.ProcessorDataIn), 64'd0);
        chk("rst_host_data", 64'(bus_a.hostDataOut), 64'd0);
        chk("rst_rd_valid", 64'(bus_a.hostRdValid), 64'd0);
        chk("rst_busy", 64'(bus_a.hostBusy), 64'd0);
        chk("rst_run_cycles", 64'(bus_a.runCycles), 64'd0);
        rst_n = 1'b1;
        tick();

        // Host load/dump of row 0x005 lane by lane
        host_write(12'h005, 2'd0, 12'h111);
        host_write(12'h005, 2'd1, 12'h222);
        host_write(12'h005, 2'd3, 12'h333);
        host_write(12'h005, 2'd2, 12'hABC);
        host_read(12'h005, 2'd2, 12'hABC, 1'b1);
        host_read(12'h005, 2'd0, 12'h111, 1'b1);
        host_read(12'h005, 2'd1, 12'h222, 1'b1);
        host_read(12'h005, 2'd3, 12'h333, 1'b1);

        // Write+read together: write wins, read dropped
        bus_a.hostRdEn = 1'b1;
        host_write(12'h005, 2'd1, 12'h7E7);
        bus_a.hostRdEn = 1'b0;
        chk("wr_rd_collision_no_valid", 64'(bus_a.hostRdValid), 64'd0);
        host_read(12'h005, 2'd1, 12'h7E7, 1'b1);

        // Preload row 0x010 via the host
        host_write(12'h010, 2'd0, 12'h0AA);
        host_write(12'h010, 2'd1, 12'h0BB);
        host_write(12'h010, 2'd2, 12'h0CC);
        host_write(12'h010, 2'd3, 12'h0DD);

        // Processor write in HOST is ignored
        bus_a.dataMemAddr = 12'h010;
        bus_a.ProcessorDataOut = 48'hFFF_FFF_FFF_FFF;
        bus_a.DataMemWrEn = 1'b1;
        tick();
        bus_a.DataMemWrEn = 1'b0;
        tick();
        chk("host_state_proc_wr_ignored", 64'(bus_a.ProcessorDataIn), 64'h0DD0CC0BB0AA);

        // Start with a host read in the same cycle: still served (E0)
        bus_a.start = 1'b1;
        bus_a.hostAddr = 12'h005; bus_a.hostLane = 2'd2; bus_a.hostRdEn = 1'b1;
        exp_q.push_back(12'hABC);
        tick();
        bus_a.start = 1'b0; bus_a.hostRdEn = 1'b0;
        chk("busy_after_start", 64'(bus_a.hostBusy), 64'd1);
        chk("run_cycles_first", 64'(bus_a.runCycles), 64'd1);

        // Processor row write, read-first then new data (E1, E2)
        bus_a.ProcessorDataOut = 48'h444_333_222_111;
        bus_a.DataMemWrEn = 1'b1;
        tick();
        bus_a.DataMemWrEn = 1'b0;
        chk("proc_read_first_old", 64'(bus_a.ProcessorDataIn), 64'h0DD0CC0BB0AA);
        tick();
        chk("proc_read_new_row", 64'(bus_a.ProcessorDataIn), 64'h444333222111);

        // Host requests dropped in RUN (E3, E4)
        host_write(12'h005, 2'd2, 12'h555);
        chk("busy_in_run", 64'(bus_a.hostBusy), 64'd1);
        host_read(12'h005, 2'd2, 12'h000, 1'b0);
        chk("run_host_read_dropped", 64'(bus_a.hostRdValid), 64'd0);

        repeat (5) tick();  // E5..E9

        // done with start together, plus a host write in the done cycle (E10)
        bus_a.done = 1'b1; bus_a.start = 1'b1;
        bus_a.hostAddr = 12'h005; bus_a.hostLane = 2'd2; bus_a.hostDataIn = 12'h666;
        bus_a.hostWrEn = 1'b1;
        tick();
        bus_a.done = 1'b0; bus_a.start = 1'b0; bus_a.hostWrEn = 1'b0;
        chk("done_wins_busy_low", 64'(bus_a.hostBusy), 64'd0);
        chk("run_cycles_ten", 64'(bus_a.runCycles), 64'd10);
        tick();
        chk("run_cycles_hold", 64'(bus_a.runCycles), 64'd10);
        host_read(12'h005, 2'd2, 12'hABC, 1'b1);

        // start held for three cycles: one run only
        bus_a.start = 1'b1;
        repeat (3) tick();
        bus_a.start = 1'b0;
        repeat (2) tick();
        bus_a.done = 1'b1;
        tick();
        bus_a.done = 1'b0;
        chk("held_start_single_run", 64'(bus_a.runCycles), 64'd5);

        // Reset mid-run with a host read pending
        bus_a.start = 1'b1;
        bus_a.hostAddr = 12'h005; bus_a.hostLane = 2'd0; bus_a.hostRdEn = 1'b1;
        tick();
        bus_a.start = 1'b0; bus_a.hostRdEn = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus_a.hostBusy), 64'd0);
        chk("midrst_rd_valid", 64'(bus_a.hostRdValid), 64'd0);
        chk("midrst_run_cycles", 64'(bus_a.runCycles), 64'd0);
        chk("midrst_host_data", 64'(bus_a.hostDataOut), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("mem_kept_after_reset", 64'(bus_a.ProcessorDataIn), 64'h444333222111);

        // Instance B: 3 lanes, out-of-range lane dropped
        bus_b.hostAddr = 4'h2;
        bus_b.hostWrEn = 1'b1;
        bus_b.hostLane = 2'd0; bus_b.hostDataIn = 12'h123; tick();
        bus_b.hostLane = 2'd1; bus_b.hostDataIn = 12'h456; tick();
        bus_b.hostLane = 2'd2; bus_b.hostDataIn = 12'h789; tick();
        bus_b.hostLane = 2'd3; bus_b.hostDataIn = 12'hFFF; tick();
        bus_b.hostWrEn = 1'b0;
        bus_b.hostRdEn = 1'b1;
        tick();
        bus_b.hostRdEn = 1'b0;
        chk("b_bad_lane_no_valid", 64'(bus_b.hostRdValid), 64'd0);
        bus_b.hostLane = 2'd0; bus_b.hostRdEn = 1'b1;
        tick();
        bus_b.hostRdEn = 1'b0;
        chk("b_lane0_valid", 64'(bus_b.hostRdValid), 64'd1);
        chk("b_lane0_data", 64'(bus_b.hostDataOut), 64'h123);
        bus_b.dataMemAddr = 4'h2;
        tick();
        chk("b_row_intact", 64'(bus_b.ProcessorDataIn), 64'h789456123);

        // Instance B: 20-cycle run saturates a 4-bit counter
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        repeat (19) tick();
        bus_b.done = 1'b1;
        tick();
        bus_b.done = 1'b0;
        chk("b_run_cycles_saturate", 64'(bus_b.runCycles), 64'd15);
        chk("b_busy_after_done", 64'(bus_b.hostBusy), 64'd0);

        repeat (2) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
